// File: rtl/clct_second_pass_seq_cclut.sv
// Second-pass sequencer for the ccLUT pattern finder. It holds the first-pass best CLCT,
// drives a key half-strip busy mask for the second pass, and emits the CLCT pair.
module clct_second_pass_seq_cclut #(
    parameter int MXHS    = 224,
    parameter int MXKEYBX = 8,
    parameter int MXPATB  = 6,
    parameter int MXQLTB  = 9,
    parameter int MXBNDB  = 5,
    parameter int MXPATC  = 12,
    parameter int MXXKYB  = 10,
    parameter int SPREAD  = 7,
    parameter int PAT_THR = 1,
    parameter int TMO     = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               first_vld,
    input  logic               second_vld,
    input  logic [MXPATB-1:0]  best_pat,
    input  logic [MXKEYBX-1:0] best_key,
    input  logic [MXBNDB-1:0]  best_bend,
    input  logic [MXPATC-1:0]  best_carry,
    input  logic [MXXKYB-1:0]  best_subkey,
    input  logic [MXQLTB-1:0]  best_qlt,
    input  logic               best_bsy,
    output logic [MXHS-1:0]    hs_busy,
    output logic               clct_vld,
    output logic               clct0_vld,
    output logic               clct1_vld,
    output logic [MXPATB-1:0]  clct0_pat,
    output logic [MXPATB-1:0]  clct1_pat,
    output logic [MXKEYBX-1:0] clct0_key,
    output logic [MXKEYBX-1:0] clct1_key,
    output logic [MXBNDB-1:0]  clct0_bend,
    output logic [MXBNDB-1:0]  clct1_bend,
    output logic [MXPATC-1:0]  clct0_carry,
    output logic [MXPATC-1:0]  clct1_carry,
    output logic [MXXKYB-1:0]  clct0_subkey,
    output logic [MXXKYB-1:0]  clct1_subkey,
    output logic [MXQLTB-1:0]  clct0_qlt,
    output logic [MXQLTB-1:0]  clct1_qlt,
    output logic [7:0]         drop_cnt,
    output logic               seq_busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WAIT2 = 1'b1;

    localparam logic signed [9:0] SPR    = 10'(SPREAD);
    localparam logic signed [9:0] HS_MAX = 10'(MXHS - 1);

    typedef struct packed {
        logic [MXPATB-1:0]  pat;
        logic [MXKEYBX-1:0] key;
        logic [MXBNDB-1:0]  bend;
        logic [MXPATC-1:0]  carry;
        logic [MXXKYB-1:0]  subkey;
        logic [MXQLTB-1:0]  qlt;
    } clct_t;

    logic [0:0]       r_state;
    logic [3:0]       r_timer;
    logic [7:0]       r_drop;
    logic [MXHS-1:0]  r_hs_busy;
    clct_t            r_hold;
    clct_t            r_clct0;
    clct_t            r_clct1;
    logic             r_clct_vld;
    logic             r_clct0_vld;
    logic             r_clct1_vld;

    clct_t            w_best;
    logic             w_acc;
    logic signed [9:0] w_key_s;
    logic signed [9:0] w_lo;
    logic signed [9:0] w_hi;
    logic [MXHS-1:0]  w_mask;

    assign w_best  = {best_pat, best_key, best_bend, best_carry, best_subkey, best_qlt};
    assign w_acc   = !best_bsy && (best_pat >= MXPATB'(PAT_THR));

    // Signed, wider-than-key arithmetic so the window clamps instead of wrapping at either edge.
    assign w_key_s = $signed(10'(best_key));
    assign w_lo    = (w_key_s - SPR < 0) ? 10'sd0 : w_key_s - SPR;
    assign w_hi    = (w_key_s + SPR > HS_MAX) ? HS_MAX : w_key_s + SPR;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MXHS; i++) begin
            w_mask[i] = ($signed(10'(i)) >= w_lo) && ($signed(10'(i)) <= w_hi);
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_drop      <= '0;
            r_hs_busy   <= '0;
            r_hold      <= '0;
            r_clct0     <= '0;
            r_clct1     <= '0;
            r_clct_vld  <= 1'b0;
            r_clct0_vld <= 1'b0;
            r_clct1_vld <= 1'b0;
        end else begin
            r_clct_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (first_vld && w_acc) begin
                        r_hold    <= w_best;
                        r_hs_busy <= w_mask;
                        r_timer   <= '0;
                        r_state   <= S_WAIT2;
                    end
                end
                S_WAIT2: begin
                    if (first_vld && (r_drop != 8'hFF)) begin
                        r_drop <= r_drop + 8'd1;
                    end
                    // A real second pass wins over the timeout on the same edge.
                    if (second_vld || (r_timer == 4'(TMO - 1))) begin
                        r_clct0     <= r_hold;
                        r_clct0_vld <= 1'b1;
                        r_clct1     <= (second_vld && w_acc) ? w_best : '0;
                        r_clct1_vld <= second_vld && w_acc;
                        r_clct_vld  <= 1'b1;
                        r_hs_busy   <= '0;
                        r_timer     <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 4'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_hs_busy <= '0;
                end
            endcase
        end
    end

    assign hs_busy      = r_hs_busy;
    assign clct_vld     = r_clct_vld;
    assign clct0_vld    = r_clct0_vld;
    assign clct1_vld    = r_clct1_vld;
    assign clct0_pat    = r_clct0.pat;
    assign clct1_pat    = r_clct1.pat;
    assign clct0_key    = r_clct0.key;
    assign clct1_key    = r_clct1.key;
    assign clct0_bend   = r_clct0.bend;
    assign clct1_bend   = r_clct1.bend;
    assign clct0_carry  = r_clct0.carry;
    assign clct1_carry  = r_clct1.carry;
    assign clct0_subkey = r_clct0.subkey;
    assign clct1_subkey = r_clct1.subkey;
    assign clct0_qlt    = r_clct0.qlt;
    assign clct1_qlt    = r_clct1.qlt;
    assign drop_cnt     = r_drop;
    assign seq_busy     = (r_state == S_WAIT2);

endmodule

// File: tb/tb_clct_second_pass_seq_cclut.sv
// Directed bench for clct_second_pass_seq_cclut: a per-cycle vector table plus
// hand-written timeout, asynchronous reset and drop-saturation sequences.
module tb_clct_second_pass_seq_cclut;

    localparam int MXHS = 224;
    localparam int TMO  = 15;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        first_vld = 1'b0;
    logic        second_vld = 1'b0;
    logic [5:0]  best_pat = '0;
    logic [7:0]  best_key = '0;
    logic [4:0]  best_bend;
    logic [11:0] best_carry;
    logic [9:0]  best_subkey;
    logic [8:0]  best_qlt;
    logic        best_bsy = 1'b0;
    logic [MXHS-1:0] hs_busy;
    logic        clct_vld, clct0_vld, clct1_vld;
    logic [5:0]  clct0_pat, clct1_pat;
    logic [7:0]  clct0_key, clct1_key;
    logic [4:0]  clct0_bend, clct1_bend;
    logic [11:0] clct0_carry, clct1_carry;
    logic [9:0]  clct0_subkey, clct1_subkey;
    logic [8:0]  clct0_qlt, clct1_qlt;
    logic [7:0]  drop_cnt;
    logic        seq_busy;

    int n_pass = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    // Side fields are derived from pattern and key so each CLCT is distinguishable end to end.
    assign best_bend   = 5'(best_key ^ 8'h15);
    assign best_carry  = 12'(best_key * 5 + best_pat);
    assign best_subkey = {best_key, 2'b01};
    assign best_qlt    = 9'(best_pat * 7 + 1);

    clct_second_pass_seq_cclut dut (
        .clock(clock), .reset_n(reset_n), .first_vld(first_vld), .second_vld(second_vld),
        .best_pat(best_pat), .best_key(best_key), .best_bend(best_bend), .best_carry(best_carry),
        .best_subkey(best_subkey), .best_qlt(best_qlt), .best_bsy(best_bsy),
        .hs_busy(hs_busy), .clct_vld(clct_vld), .clct0_vld(clct0_vld), .clct1_vld(clct1_vld),
        .clct0_pat(clct0_pat), .clct1_pat(clct1_pat), .clct0_key(clct0_key), .clct1_key(clct1_key),
        .clct0_bend(clct0_bend), .clct1_bend(clct1_bend), .clct0_carry(clct0_carry),
        .clct1_carry(clct1_carry), .clct0_subkey(clct0_subkey), .clct1_subkey(clct1_subkey),
        .clct0_qlt(clct0_qlt), .clct1_qlt(clct1_qlt), .drop_cnt(drop_cnt), .seq_busy(seq_busy)
    );

    typedef struct {
        logic first, second, bsy;
        int   pat, key;
        logic e_vld, e_c0v, e_c1v, e_seq;
        int   e_p0, e_k0, e_p1, e_k1;
        int   e_lo, e_hi;   // e_lo < 0 means mask all zero
        int   e_drop;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [49:0] fields(input int p, input int k);
        logic [7:0] kk;
        logic [5:0] pp;
        kk = 8'(k);
        pp = 6'(p);
        return {pp, kk, 5'(kk ^ 8'h15), 12'(k * 5 + p), {kk, 2'b01}, 9'(p * 7 + 1)};
    endfunction

    function automatic logic [MXHS-1:0] mask(input int lo, input int hi);
        logic [MXHS-1:0] m;
        m = '0;
        if (lo >= 0) for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [49:0] c0_act();
        return {clct0_pat, clct0_key, clct0_bend, clct0_carry, clct0_subkey, clct0_qlt};
    endfunction

    function automatic logic [49:0] c1_act();
        return {clct1_pat, clct1_key, clct1_bend, clct1_carry, clct1_subkey, clct1_qlt};
    endfunction

    task automatic drive(input logic f, input logic s, input logic b, input int p, input int k);
        first_vld  = f;
        second_vld = s;
        best_bsy   = b;
        best_pat   = 6'(p);
        best_key   = 8'(k);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //           f  s  bsy pat key  vld c0v c1v seq  p0  k0  p1  k1  lo   hi   drop
        vecs[0]  = '{0, 0, 0,  0,  0,   0,  0,  0,  0,   0,  0,  0,  0,  -1,  0,   0};
        vecs[1]  = '{1, 0, 0,  10, 100, 0,  0,  0,  1,   0,  0,  0,  0,  93,  107, 0};
        vecs[2]  = '{0, 0, 0,  0,  0,   0,  0,  0,  1,   0,  0,  0,  0,  93,  107, 0};
        vecs[3]  = '{0, 0, 0,  0,  0,   0,  0,  0,  1,   0,  0,  0,  0,  93,  107, 0};
        vecs[4]  = '{0, 1, 0,  8,  40,  1,  1,  1,  0,   10, 100, 8, 40, -1,  0,   0};
        vecs[5]  = '{0, 0, 0,  0,  0,   0,  1,  1,  0,   10, 100, 8, 40, -1,  0,   0};
        vecs[6]  = '{1, 0, 1,  10, 3,   0,  1,  1,  0,   10, 100, 8, 40, -1,  0,   0};
        vecs[7]  = '{1, 0, 0,  10, 3,   0,  1,  1,  1,   10, 100, 8, 40, 0,   10,  0};
        vecs[8]  = '{0, 1, 0,  0,  50,  1,  1,  0,  0,   10, 3,   -1, -1, -1, 0,   0};
        vecs[9]  = '{1, 0, 0,  5,  220, 0,  1,  0,  1,   10, 3,   -1, -1, 213, 223, 0};
        vecs[10] = '{1, 1, 0,  1,  7,   1,  1,  1,  0,   5,  220, 1,  7,  -1,  0,   1};
        vecs[11] = '{0, 1, 0,  9,  60,  0,  1,  1,  0,   5,  220, 1,  7,  -1,  0,   1};
        vecs[12] = '{1, 0, 0,  0,  10,  0,  1,  1,  0,   5,  220, 1,  7,  -1,  0,   1};

        drive(0, 0, 0, 0, 0);
        #12;
        check("reset_busy", 256'(hs_busy), 256'(0));
        check("reset_vld", 256'({clct_vld, clct0_vld, clct1_vld, seq_busy}), 256'(0));
        check("reset_drop", 256'(drop_cnt), 256'(0));
        @(negedge clock);
        reset_n = 1'b1;

        for (int v = 0; v < 13; v++) begin
            @(negedge clock);
            drive(vecs[v].first, vecs[v].second, vecs[v].bsy, vecs[v].pat, vecs[v].key);
            step();
            check($sformatf("v%0d_clct_vld", v), 256'(clct_vld), 256'(vecs[v].e_vld));
            check($sformatf("v%0d_c0v", v), 256'(clct0_vld), 256'(vecs[v].e_c0v));
            check($sformatf("v%0d_c1v", v), 256'(clct1_vld), 256'(vecs[v].e_c1v));
            check($sformatf("v%0d_seq_busy", v), 256'(seq_busy), 256'(vecs[v].e_seq));
            check($sformatf("v%0d_clct0", v), 256'(c0_act()),
                  (vecs[v].e_k0 < 0 || !vecs[v].e_c0v) ? 256'(0) : 256'(fields(vecs[v].e_p0, vecs[v].e_k0)));
            check($sformatf("v%0d_clct1", v), 256'(c1_act()),
                  (vecs[v].e_k1 < 0 || !vecs[v].e_c0v) ? 256'(0) : 256'(fields(vecs[v].e_p1, vecs[v].e_k1)));
            check($sformatf("v%0d_hs_busy", v), 256'(hs_busy), 256'(mask(vecs[v].e_lo, vecs[v].e_hi)));
            check($sformatf("v%0d_drop", v), 256'(drop_cnt), 256'(vecs[v].e_drop));
        end

        // Timeout: accepted first pass at key 0, then silence until the fallback fires.
        @(negedge clock);
        drive(1, 0, 0, 2, 0);
        step();
        check("tmo_busy_lo_edge", 256'(hs_busy), 256'(mask(0, 7)));
        drive(0, 0, 0, 0, 0);
        for (int k = 1; k < TMO; k++) begin
            step();
            check($sformatf("tmo_quiet_%0d", k), 256'(clct_vld), 256'(0));
        end
        step();
        check("tmo_clct_vld", 256'(clct_vld), 256'(1));
        check("tmo_c0v_c1v", 256'({clct0_vld, clct1_vld}), 256'(2'b10));
        check("tmo_clct0", 256'(c0_act()), 256'(fields(2, 0)));
        check("tmo_clct1", 256'(c1_act()), 256'(0));
        check("tmo_busy_clr", 256'({hs_busy, seq_busy}), 256'(0));
        step();
        check("tmo_pulse_end", 256'(clct_vld), 256'(0));

        // Asynchronous reset in the middle of WAIT2.
        @(negedge clock);
        drive(1, 0, 0, 10, 100);
        step();
        check("rst_pre_seq", 256'(seq_busy), 256'(1));
        drive(0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_busy", 256'(hs_busy), 256'(0));
        check("rst_async_flags", 256'({clct_vld, clct0_vld, clct1_vld, seq_busy}), 256'(0));
        check("rst_async_drop", 256'(drop_cnt), 256'(0));
        check("rst_async_clct0", 256'(c0_act()), 256'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // Continuous accepted first_vld: one capture then 15 drops per 16-cycle round.
        @(negedge clock);
        drive(1, 0, 0, 3, 120);
        for (int c = 0; c < 16; c++) step();
        check("drop_one_round", 256'(drop_cnt), 256'(15));
        check("drop_round_vld", 256'({clct_vld, clct1_vld}), 256'(2'b10));
        for (int c = 0; c < 384; c++) step();
        check("drop_saturate", 256'(drop_cnt), 256'(255));
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) step();
        check("drop_held", 256'(drop_cnt), 256'(255));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
